// File: rtl/vec_lane_req_sequencer.sv
// Lane-side initiator for the lane-to-vector-register crossbar.
// Takes one vector access command from the lane and splits it into
// per-element crossbar requests. Write elements flow straight through from
// the lane. Read responses come back one cycle after their grant and are
// re-registered towards the lane.
module vec_lane_req_sequencer #(
    parameter int NUM_OF_VECTOR_REG = 8,
    parameter int VECTOR_REG_DEPTH  = 128,
    parameter int VECTOR_REG_WIDTH  = 64,
    parameter int MAX_OUTSTANDING   = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 cmd_vld,
    output logic                                 cmd_rdy,
    input  logic                                 cmd_type,
    input  logic [$clog2(NUM_OF_VECTOR_REG)-1:0] cmd_reg_ptr,
    input  logic [$clog2(VECTOR_REG_DEPTH)-1:0]  cmd_addr,
    input  logic [7:0]                           cmd_length,
    input  logic                                 wr_data_vld,
    input  logic [VECTOR_REG_WIDTH-1:0]          wr_data,
    output logic                                 wr_data_rdy,
    output logic                                 req_vld,
    output logic                                 req_type,
    output logic [$clog2(NUM_OF_VECTOR_REG)-1:0] req_reg_ptr,
    output logic [$clog2(VECTOR_REG_DEPTH)-1:0]  req_addr,
    output logic [VECTOR_REG_WIDTH-1:0]          req_data,
    output logic [7:0]                           req_access_length,
    input  logic                                 req_gnt,
    input  logic                                 rsp_vld,
    input  logic [VECTOR_REG_WIDTH-1:0]          rsp_data,
    output logic                                 rd_data_vld,
    output logic [VECTOR_REG_WIDTH-1:0]          rd_data,
    output logic                                 rd_last,
    output logic                                 done,
    output logic                                 busy,
    output logic                                 err
);

    localparam int PTR_W  = $clog2(NUM_OF_VECTOR_REG);
    localparam int ADDR_W = $clog2(VECTOR_REG_DEPTH);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [OUT_W-1:0]  MAX_OUT   = OUT_W'(MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0]  OUT_ZERO  = {OUT_W{1'b0}};
    localparam logic [OUT_W-1:0]  OUT_ONE   = OUT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(VECTOR_REG_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_type;
    logic [PTR_W-1:0]        r_reg_ptr;
    logic [ADDR_W-1:0]       r_addr;
    logic [7:0]              r_remaining;
    logic [7:0]              r_rsp_left;
    logic [OUT_W-1:0]        r_outstanding;
    logic                    r_rd_vld;
    logic [VECTOR_REG_WIDTH-1:0] r_rd_data;
    logic                    r_rd_last;
    logic                    r_done;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_req_vld;
    logic                    w_issue;
    logic                    w_rsp_ok;
    logic                    w_rsp_last;

    assign w_accept   = cmd_vld && (r_state == S_IDLE);
    assign w_issue    = w_req_vld && req_gnt;
    // A response with nothing outstanding is flagged, never forwarded.
    assign w_rsp_ok   = rsp_vld && (r_outstanding != OUT_ZERO);
    assign w_rsp_last = w_rsp_ok && (r_rsp_left == 8'd1);

    // Next-state and request-valid decode.
    always_comb begin
        w_next_state = r_state;
        w_req_vld    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (cmd_length != 8'd0)) begin
                    w_next_state = S_ISSUE;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (r_type) begin
                    w_req_vld = wr_data_vld;
                end else begin
                    w_req_vld = (r_outstanding < MAX_OUT);
                end
                if (w_req_vld && req_gnt && (r_remaining == 8'd1)) begin
                    w_next_state = r_type ? S_IDLE : S_DRAIN;
                end else begin
                    w_next_state = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (w_rsp_ok && (r_outstanding == OUT_ONE)) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DRAIN;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Command capture and per-issue address/remaining advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_type      <= 1'b0;
            r_reg_ptr   <= {PTR_W{1'b0}};
            r_addr      <= {ADDR_W{1'b0}};
            r_remaining <= 8'd0;
        end else if (w_accept) begin
            r_type      <= cmd_type;
            r_reg_ptr   <= cmd_reg_ptr;
            r_addr      <= cmd_addr;
            r_remaining <= cmd_length;
        end else if (w_issue) begin
            r_addr      <= (r_addr == ADDR_LAST) ? {ADDR_W{1'b0}} : (r_addr + ADDR_W'(1));
            r_remaining <= r_remaining - 8'd1;
        end
    end

    // Count of read responses still owed to the lane, used to mark the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_left <= 8'd0;
        end else if (w_accept) begin
            r_rsp_left <= cmd_type ? 8'd0 : cmd_length;
        end else if (w_rsp_ok) begin
            r_rsp_left <= r_rsp_left - 8'd1;
        end
    end

    // Granted reads awaiting their response; issue and response together cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outstanding <= OUT_ZERO;
        end else begin
            case ({w_issue && !r_type, w_rsp_ok})
                2'b10:   r_outstanding <= r_outstanding + OUT_ONE;
                2'b01:   r_outstanding <= r_outstanding - OUT_ONE;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Read return path, completion pulse and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_vld  <= 1'b0;
            r_rd_data <= {VECTOR_REG_WIDTH{1'b0}};
            r_rd_last <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_rd_vld  <= w_rsp_ok;
            r_rd_data <= w_rsp_ok ? rsp_data : r_rd_data;
            r_rd_last <= w_rsp_last;
            r_done    <= (w_accept && (cmd_length == 8'd0))
                      || (w_issue && r_type && (r_remaining == 8'd1))
                      || w_rsp_last;
            r_err     <= r_err || (rsp_vld && (r_outstanding == OUT_ZERO));
        end
    end

    assign cmd_rdy           = (r_state == S_IDLE);
    assign busy              = (r_state != S_IDLE);
    assign req_vld           = w_req_vld;
    assign req_type          = r_type;
    assign req_reg_ptr       = r_reg_ptr;
    assign req_addr          = r_addr;
    assign req_access_length = r_remaining;
    assign req_data          = ((r_state == S_ISSUE) && r_type) ? wr_data : {VECTOR_REG_WIDTH{1'b0}};
    assign wr_data_rdy       = w_issue && r_type;
    assign rd_data_vld       = r_rd_vld;
    assign rd_data           = r_rd_data;
    assign rd_last           = r_rd_last;
    assign done              = r_done;
    assign err               = r_err;

endmodule
